// File: rtl/core_seq.sv
`default_nettype none
// ============================================================================
// Module   : core_seq
// Purpose  : Initiator side of the per-core matrix / exec / accumulator-chain
//            interface. It loads matrix rows into a chain of N_CORE MAC cores,
//            streams one source vector to every core, waits for the core
//            pipeline to drain, then shifts the accumulators out of the chain
//            head onto a valid/ready result stream.
// Ports    : clk, rst                      - clock, synchronous active-high reset
//            start_load/start_run/run_len  - command inputs (sampled in IDLE)
//            busy, done                    - status
//            s_mat_*                       - 64-bit matrix input stream
//            s_src_*                       - 32-bit source vector stream
//            mat_v/mat_a/mat_d             - core matrix write port
//            init/exec/exec_mat_addr/exec_src_data - core exec broadcast
//            update/out_period/acc_in      - accumulator chain control/head
//            m_res_*                       - 32-bit result stream
// Revision : 1.0 - initial release
// ============================================================================
module core_seq #(
  parameter int N_CORE    = 8,
  parameter int MAT_DEPTH = 128,
  parameter int ADDR_W    = 7,
  parameter int PIPE_LAT  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_load,
  input  logic              start_run,
  input  logic [ADDR_W:0]   run_len,
  output logic              busy,
  output logic              done,
  input  logic              s_mat_valid,
  output logic              s_mat_ready,
  input  logic [63:0]       s_mat_data,
  input  logic              s_src_valid,
  output logic              s_src_ready,
  input  logic [31:0]       s_src_data,
  output logic [N_CORE-1:0] mat_v,
  output logic [ADDR_W-1:0] mat_a,
  output logic [64:0]       mat_d,
  output logic              init,
  output logic              exec,
  output logic [ADDR_W-1:0] exec_mat_addr,
  output logic [31:0]       exec_src_data,
  output logic              update,
  output logic              out_period,
  input  logic [31:0]       acc_in,
  output logic              m_res_valid,
  input  logic              m_res_ready,
  output logic [31:0]       m_res_data
);

  localparam int HALF_DEPTH = MAT_DEPTH / 2;
  localparam int BEAT_W     = $clog2(HALF_DEPTH);
  localparam int CORE_W     = (N_CORE > 1) ? $clog2(N_CORE) : 1;
  localparam int DRAIN_W    = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  localparam logic [BEAT_W-1:0]  LAST_BEAT  = BEAT_W'(HALF_DEPTH - 1);
  localparam logic [BEAT_W-1:0]  BEAT_ONE   = BEAT_W'(1);
  localparam logic [CORE_W-1:0]  LAST_CORE  = CORE_W'(N_CORE - 1);
  localparam logic [CORE_W-1:0]  CORE_ONE   = CORE_W'(1);
  localparam logic [DRAIN_W-1:0] LAST_DRAIN = DRAIN_W'(PIPE_LAT - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_ONE  = DRAIN_W'(1);
  localparam logic [ADDR_W:0]    FULL_LEN   = (ADDR_W + 1)'(MAT_DEPTH);
  localparam logic [ADDR_W:0]    LEN_ONE    = (ADDR_W + 1)'(1);
  localparam logic [N_CORE-1:0]  CORE0_SEL  = N_CORE'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    INIT  = 3'd2,
    EXEC  = 3'd3,
    DRAIN = 3'd4,
    OUT   = 3'd5
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [CORE_W-1:0]  r_core;   // core being written during LOAD
  logic [BEAT_W-1:0]  r_beat;   // beat within the current core's row
  logic [ADDR_W:0]    r_len;    // clamped vector length of this run
  logic [ADDR_W:0]    r_idx;    // source elements accepted so far
  logic [DRAIN_W-1:0] r_drain;  // cycles spent in DRAIN
  logic [CORE_W-1:0]  r_out;    // results transferred so far

  logic              w_mat_hs;
  logic              w_src_hs;
  logic              w_res_hs;
  logic              w_load_last;
  logic              w_exec_last;
  logic              w_drain_last;
  logic              w_out_last;
  logic [ADDR_W:0]   w_len_clamped;

  // Handshakes are decoded from the state directly (not from the ready
  // outputs) so the next-state logic has no combinational feedback.
  assign w_mat_hs      = (r_state == LOAD) && s_mat_valid;
  assign w_src_hs      = (r_state == EXEC) && s_src_valid;
  assign w_res_hs      = (r_state == OUT)  && m_res_ready;
  assign w_load_last   = w_mat_hs && (r_beat == LAST_BEAT) && (r_core == LAST_CORE);
  assign w_exec_last   = w_src_hs && ((r_idx + LEN_ONE) == r_len);
  assign w_drain_last  = (r_state == DRAIN) && (r_drain == LAST_DRAIN);
  assign w_out_last    = w_res_hs && (r_out == LAST_CORE);
  assign w_len_clamped = ((run_len == '0) || (run_len > FULL_LEN)) ? FULL_LEN : run_len;

  // Next state and the combinational handshake / result outputs.
  always_comb begin
    w_state_nxt = r_state;
    busy        = (r_state != IDLE);
    s_mat_ready = 1'b0;
    s_src_ready = 1'b0;
    m_res_valid = 1'b0;
    m_res_data  = '0;
    out_period  = 1'b0;
    update      = 1'b0;
    case (r_state)
      IDLE: begin
        // Load has priority; a simultaneous start_run is dropped.
        if (start_load) begin
          w_state_nxt = LOAD;
        end else if (start_run) begin
          w_state_nxt = INIT;
        end
      end
      LOAD: begin
        s_mat_ready = 1'b1;
        if (w_load_last) w_state_nxt = IDLE;
      end
      INIT: begin
        w_state_nxt = EXEC;
      end
      EXEC: begin
        s_src_ready = 1'b1;
        if (w_exec_last) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (w_drain_last) w_state_nxt = OUT;
      end
      OUT: begin
        m_res_valid = 1'b1;
        m_res_data  = acc_in;
        out_period  = m_res_ready;
        // Cores capture their accumulators into the chain on the first shift.
        update      = m_res_ready && (r_out == '0);
        if (w_out_last) w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State register, counters and registered core-side outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_core        <= '0;
      r_beat        <= '0;
      r_len         <= '0;
      r_idx         <= '0;
      r_drain       <= '0;
      r_out         <= '0;
      done          <= 1'b0;
      mat_v         <= '0;
      mat_a         <= '0;
      mat_d         <= '0;
      init          <= 1'b0;
      exec          <= 1'b0;
      exec_mat_addr <= '0;
      exec_src_data <= '0;
    end else begin
      r_state <= w_state_nxt;
      done    <= w_load_last || w_out_last;
      mat_v   <= '0;
      // Registered from INIT, so init lands in the first EXEC cycle and always
      // leads the first exec strobe (itself registered) by at least a cycle.
      init    <= (r_state == INIT);
      exec    <= w_src_hs;
      case (r_state)
        IDLE: begin
          if (start_run && !start_load) r_len <= w_len_clamped;
        end
        LOAD: begin
          if (w_mat_hs) begin
            mat_v <= CORE0_SEL << r_core;
            mat_a <= ADDR_W'({r_beat, 1'b0});
            mat_d <= {(r_beat == LAST_BEAT), s_mat_data};
            if (r_beat == LAST_BEAT) begin
              r_beat <= '0;
              r_core <= (r_core == LAST_CORE) ? '0 : r_core + CORE_ONE;
            end else begin
              r_beat <= r_beat + BEAT_ONE;
            end
          end
        end
        EXEC: begin
          if (w_src_hs) begin
            exec_mat_addr <= r_idx[ADDR_W-1:0];
            exec_src_data <= s_src_data;
            r_idx         <= w_exec_last ? '0 : r_idx + LEN_ONE;
          end
        end
        DRAIN: begin
          r_drain <= w_drain_last ? '0 : r_drain + DRAIN_ONE;
        end
        OUT: begin
          if (w_res_hs) r_out <= w_out_last ? '0 : r_out + CORE_ONE;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_core_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_core_seq
// Purpose  : Self-checking bench for core_seq. A behavioural core array (row
//            memories, PIPE_LAT-deep accumulate pipeline, shift chain) sits on
//            the core side; directed run vectors with hand-computed results
//            are applied from a table, plus hand-written load/reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_core_seq;

  localparam int N_CORE    = 8;
  localparam int MAT_DEPTH = 128;
  localparam int ADDR_W    = 7;
  localparam int PIPE_LAT  = 3;
  localparam int HALF      = MAT_DEPTH / 2;
  localparam int TOTAL     = N_CORE * HALF;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start_load = 1'b0;
  logic              start_run = 1'b0;
  logic [ADDR_W:0]   run_len = '0;
  logic              busy, done;
  logic              s_mat_valid = 1'b0;
  logic              s_mat_ready;
  logic [63:0]       s_mat_data = '0;
  logic              s_src_valid = 1'b0;
  logic              s_src_ready;
  logic [31:0]       s_src_data = '0;
  logic [N_CORE-1:0] mat_v;
  logic [ADDR_W-1:0] mat_a;
  logic [64:0]       mat_d;
  logic              init, exec;
  logic [ADDR_W-1:0] exec_mat_addr;
  logic [31:0]       exec_src_data;
  logic              update, out_period;
  logic [31:0]       acc_in;
  logic              m_res_valid;
  logic              m_res_ready = 1'b0;
  logic [31:0]       m_res_data;

  core_seq #(
    .N_CORE(N_CORE), .MAT_DEPTH(MAT_DEPTH), .ADDR_W(ADDR_W), .PIPE_LAT(PIPE_LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .start_load(start_load), .start_run(start_run), .run_len(run_len),
    .busy(busy), .done(done),
    .s_mat_valid(s_mat_valid), .s_mat_ready(s_mat_ready), .s_mat_data(s_mat_data),
    .s_src_valid(s_src_valid), .s_src_ready(s_src_ready), .s_src_data(s_src_data),
    .mat_v(mat_v), .mat_a(mat_a), .mat_d(mat_d),
    .init(init), .exec(exec), .exec_mat_addr(exec_mat_addr), .exec_src_data(exec_src_data),
    .update(update), .out_period(out_period), .acc_in(acc_in),
    .m_res_valid(m_res_valid), .m_res_ready(m_res_ready), .m_res_data(m_res_data)
  );

  always #5 clk = ~clk;

  logic [159:0] all_outs;
  assign all_outs = {busy, done, s_mat_ready, s_src_ready, mat_v, mat_a, mat_d, init, exec,
                     exec_mat_addr, exec_src_data, update, out_period, m_res_valid, m_res_data};

  // ---------------- behavioural core array ----------------
  logic [31:0]       mem [N_CORE][MAT_DEPTH];
  logic [31:0]       acc [N_CORE];
  logic              p1_v = 1'b0, p2_v = 1'b0;
  logic [ADDR_W-1:0] p1_a, p2_a;
  logic [31:0]       p1_d, p2_d;

  assign acc_in = acc[0];

  always @(posedge clk) begin
    for (int k = 0; k < N_CORE; k++) begin
      if (mat_v[k]) begin
        mem[k][int'(mat_a)]     <= mat_d[31:0];
        mem[k][int'(mat_a) + 1] <= mat_d[63:32];
      end
    end
    p1_v <= exec; p1_a <= exec_mat_addr; p1_d <= exec_src_data;
    p2_v <= p1_v; p2_a <= p1_a;          p2_d <= p1_d;
    for (int k = 0; k < N_CORE; k++) begin
      if (init) acc[k] <= '0;
      else if (out_period) acc[k] <= (k == N_CORE - 1) ? 32'd0 : acc[(k + 1) % N_CORE];
      else if (p2_v) acc[k] <= acc[k] + mem[k][int'(p2_a)] * p2_d;
    end
  end

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int                       pat;
    logic [7:0]               rl;
    int                       n;
    logic [31:0]              base;
    logic [31:0]              step;
    bit                       gaps;
    bit                       stall;
    logic [N_CORE-1:0][31:0]  exp;
  } vec_t;

  vec_t vq[$];

  task automatic add_vec(input int pat, input int rl, input int n, input int base, input int step,
                         input bit gaps, input bit stall, input logic [N_CORE-1:0][31:0] exp);
    vec_t v;
    v.pat = pat; v.rl = 8'(rl); v.n = n; v.base = 32'(base); v.step = 32'(step);
    v.gaps = gaps; v.stall = stall; v.exp = exp;
    vq.push_back(v);
  endtask

  // Load patterns: 0 = {2b+1, 2b}; 1 = core index + 1 everywhere; 2 = 3 everywhere.
  function automatic logic [63:0] word(input int pat, input int b);
    logic [31:0] lo, hi;
    case (pat)
      0:       begin lo = 32'(2 * b); hi = 32'(2 * b + 1); end
      1:       begin lo = 32'(b / HALF + 1); hi = lo; end
      default: begin lo = 32'd3; hi = lo; end
    endcase
    return {hi, lo};
  endfunction

  task automatic do_load(input int pat, input bit check, input bit poke_run);
    int b = 0;
    int cyc = 0;
    bit hs;
    logic [63:0] w;
    logic [7:0] ev;
    start_load = 1'b1;
    @(posedge clk); #1;
    start_load = 1'b0;
    chk("load_busy", busy, 1);
    while (b < TOTAL && cyc < 2000) begin
      s_mat_valid = !(check && (cyc % 5 == 3));
      w           = word(pat, b);
      s_mat_data  = w;
      start_run   = poke_run && (cyc == 10);
      run_len     = 8'd4;
      hs          = s_mat_valid && s_mat_ready;
      @(posedge clk); #1;
      cyc++;
      if (check) begin
        if (hs) begin
          ev = 8'(1 << (b / HALF));
          chk($sformatf("mat_v[%0d]", b), mat_v, ev);
          chk($sformatf("mat_a[%0d]", b), mat_a, 2 * (b % HALF));
          chk($sformatf("mat_d[%0d]", b), mat_d, {(b % HALF) == HALF - 1, w});
        end else begin
          chk("mat_v_bubble", mat_v, 0);
        end
        if (!(hs && b == TOTAL - 1)) chk("load_done_early", done, 0);
      end
      if (hs) b++;
    end
    s_mat_valid = 1'b0;
    start_run   = 1'b0;
    chk("load_beats", b, TOTAL);
    chk("load_done", done, 1);
    chk("load_idle", busy, 0);
    @(posedge clk); #1;
    chk("load_done_pulse", done, 0);
    chk("load_stays_idle", {busy, init}, 0);
  endtask

  task automatic do_run(input vec_t v);
    int cyc = 0, sent = 0, nexec = 0, ninit = 0, n = 0, nupd = 0, stalled = 0;
    int init_at = -1, first_exec = -1, last_exec = -1, valid_at = -1;
    bit hs = 1'b0;
    run_len   = v.rl;
    start_run = 1'b1;
    @(posedge clk); #1;
    start_run = 1'b0;
    chk("run_busy", busy, 1);
    while (valid_at < 0 && cyc < 600) begin
      s_src_valid = (sent < v.n) && (!v.gaps || (cyc % 2 == 1));
      s_src_data  = v.base + 32'(sent) * v.step;
      hs          = s_src_valid && s_src_ready;
      @(posedge clk); #1;
      cyc++;
      if (init) begin ninit++; init_at = cyc; end
      chk("exec_strobe", exec, hs);
      if (exec) begin
        chk($sformatf("exec_addr[%0d]", nexec), exec_mat_addr, nexec);
        chk($sformatf("exec_data[%0d]", nexec), exec_src_data, v.base + 32'(nexec) * v.step);
        if (first_exec < 0) first_exec = cyc;
        last_exec = cyc;
        nexec++;
      end
      if (hs) sent++;
      if (m_res_valid) valid_at = cyc;
    end
    s_src_valid = 1'b0;
    chk("init_count", ninit, 1);
    chk("init_lead", first_exec - init_at, 1);
    chk("exec_count", nexec, v.n);
    chk("res_latency", valid_at - last_exec, PIPE_LAT);

    cyc = 0;
    while (n < N_CORE && cyc < 100) begin
      m_res_ready = !(v.stall && n == 3 && stalled < 5);
      #1;
      chk("res_valid", m_res_valid, 1);
      chk($sformatf("res_data[%0d]", n), m_res_data, v.exp[n]);
      chk("out_period", out_period, m_res_ready);
      chk("update", update, m_res_ready && n == 0);
      if (update) nupd++;
      @(posedge clk); #1;
      cyc++;
      if (m_res_ready) n++; else stalled++;
    end
    m_res_ready = 1'b0;
    chk("res_count", n, N_CORE);
    chk("update_count", nupd, 1);
    chk("out_done", done, 1);
    chk("out_idle", {busy, m_res_valid}, 0);
    @(posedge clk); #1;
    chk("out_done_pulse", done, 0);
  endtask

  initial begin
    int cur_pat;
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cur_pat;
    //      pat rl   n   base step gaps stall expected results (core 7 .. core 0)
    add_vec(0, 4,   4,   1, 0, 0, 0, {32'd3590, 32'd3078, 32'd2566, 32'd2054,
                                      32'd1542, 32'd1030, 32'd518,  32'd6});
    add_vec(1, 4,   4,   1, 1, 0, 0, {32'd80, 32'd70, 32'd60, 32'd50, 32'd40, 32'd30, 32'd20, 32'd10});
    add_vec(1, 4,   4,   1, 1, 1, 0, {32'd80, 32'd70, 32'd60, 32'd50, 32'd40, 32'd30, 32'd20, 32'd10});
    add_vec(1, 4,   4,   1, 1, 0, 1, {32'd80, 32'd70, 32'd60, 32'd50, 32'd40, 32'd30, 32'd20, 32'd10});
    add_vec(1, 0,   128, 1, 0, 0, 0, {32'd1024, 32'd896, 32'd768, 32'd640,
                                      32'd512,  32'd384, 32'd256, 32'd128});
    add_vec(2, 1,   1,   7, 0, 0, 0, {8{32'd21}});
    add_vec(2, 200, 128, 2, 0, 0, 0, {8{32'd768}});

    // Reset: every output low.
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", all_outs, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("reset_idle", all_outs, 0);

    // Detailed load check with bubbles.
    do_load(0, 1'b1, 1'b0);
    cur_pat = 0;

    for (int i = 0; i < vq.size(); i++) begin
      if (vq[i].pat != cur_pat) begin
        // Loading pattern 1 also pokes start_run mid-LOAD, which must be ignored.
        do_load(vq[i].pat, 1'b0, vq[i].pat == 1);
        cur_pat = vq[i].pat;
      end
      do_run(vq[i]);
    end

    // Reset in the middle of EXEC aborts without a done pulse.
    run_len     = 8'd4;
    start_run   = 1'b1;
    @(posedge clk); #1;
    start_run   = 1'b0;
    s_src_valid = 1'b1;
    s_src_data  = 32'd5;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_exec", exec, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_exec_outs", all_outs, 0);
    rst         = 1'b0;
    s_src_valid = 1'b0;
    @(posedge clk); #1;
    chk("rst_no_done", {done, busy}, 0);
    do_run(vq[5]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
